tlp_tx_arbiter: RTL and testbench

//  Packet-atomic round-robin arbiter sharing the FPGA->Host TLP pipe (64-bit data/SOP/EOP/valid/ready)

---
 rtl/tlp_xcvr_pkg.sv | 11 +
 rtl/tlp_tx_arbiter_if.sv | 40 ++++
 rtl/tlp_tx_arbiter_rr_picker.sv | 38 +++
 rtl/tlp_tx_arbiter.sv | 125 ++++++++++++
 tb/tb_tlp_tx_arbiter.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/tlp_xcvr_pkg.sv
// Shared types for the TLP transmit path: beat data, requester index and packet counter.
// Combinational types only; no latency or backpressure of its own.
package tlp_xcvr_pkg;

    localparam int MAX_REQ = 8;

    typedef logic [63:0] uint64;
    typedef logic [2:0]  ReqIdx;
    typedef logic [31:0] PktCount;

endpackage

// File: rtl/tlp_tx_arbiter_if.sv
// Requester and PCIe-core side bundle of the TX arbiter; pktCount_out exists only with TLP_TX_ARB_STATS_EN.
// master = requesters + core wrapper, slave = arbiter.
interface tlp_tx_arbiter_if #(parameter int NUM_REQ = 2);
    import tlp_xcvr_pkg::*;

    uint64 [NUM_REQ-1:0] reqData_in;
    logic  [NUM_REQ-1:0] reqSOP_in;
    logic  [NUM_REQ-1:0] reqEOP_in;
    logic  [NUM_REQ-1:0] reqValid_in;
    logic  [NUM_REQ-1:0] reqReady_out;
    uint64               txData_out;
    logic                txSOP_out;
    logic                txEOP_out;
    logic                txValid_out;
    logic                txReady_in;
    logic  [NUM_REQ-1:0] grant_out;
    logic                protoErr_out;
`ifdef TLP_TX_ARB_STATS_EN
    PktCount [NUM_REQ-1:0] pktCount_out;
`endif

    modport master (
        output reqData_in, reqSOP_in, reqEOP_in, reqValid_in, txReady_in,
        input  reqReady_out, txData_out, txSOP_out, txEOP_out, txValid_out,
               grant_out, protoErr_out
`ifdef TLP_TX_ARB_STATS_EN
        , input pktCount_out
`endif
    );

    modport slave (
        input  reqData_in, reqSOP_in, reqEOP_in, reqValid_in, txReady_in,
        output reqReady_out, txData_out, txSOP_out, txEOP_out, txValid_out,
               grant_out, protoErr_out
`ifdef TLP_TX_ARB_STATS_EN
        , output pktCount_out
`endif
    );

endinterface

// File: rtl/tlp_tx_arbiter_rr_picker.sv
// Round-robin picker: first eligible index after lastGrant, wrapping.
// Purely combinational, zero latency; no backpressure.
module rr_picker
    import tlp_xcvr_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  ReqIdx              lastGrant,
    output logic               found,
    output ReqIdx              pick,
    output logic [NUM_REQ-1:0] pickOneHot
);

    int bestRank;
    int rank;

    always_comb begin
        found      = 1'b0;
        pick       = '0;
        pickOneHot = '0;
        bestRank   = NUM_REQ;
        rank       = 0;
        // rank 0 is the index right after lastGrant; lastGrant < NUM_REQ keeps it non-negative
        for (int i = 0; i < NUM_REQ; i++) begin
            rank = (i + NUM_REQ - 1 - int'(lastGrant)) % NUM_REQ;
            if (eligible[i] && (rank < bestRank)) begin
                bestRank = rank;
                found    = 1'b1;
                pick     = ReqIdx'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            pickOneHot[i] = found && (pick == ReqIdx'(i));
        end
    end

endmodule

// File: rtl/tlp_tx_arbiter.sv
// Packet-atomic round-robin arbiter for the FPGA->Host TLP pipe; optional TLP_TX_ARB_STATS_EN adds per-requester EOP counters.
// Zero-latency combinational data path from the grantee; only the grantee sees txReady_in.
// A multi-beat TLP holds the pipe until its EOP transfers; txReady_in low freezes the grant.
module tlp_tx_arbiter
    import tlp_xcvr_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic             pcieClk_in,
    input  logic             pcieNRST_in,
    tlp_tx_arbiter_if.slave  bus
);

    logic  running;
    logic  locked;
    ReqIdx owner;
    ReqIdx lastGrant;
    logic  protoErr;

    logic               found;
    ReqIdx              pick;
    logic [NUM_REQ-1:0] pickOneHot;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] ownerOneHot;
    logic [NUM_REQ-1:0] grantVec;
    uint64              txData;
    logic               txSOP;
    logic               txEOP;
    logic               txValid;
    logic               xfer;
    logic               errNow;

    assign eligible = bus.reqValid_in & bus.reqSOP_in;

    rr_picker #(.NUM_REQ(NUM_REQ)) uPicker (
        .eligible   (eligible),
        .lastGrant  (lastGrant),
        .found      (found),
        .pick       (pick),
        .pickOneHot (pickOneHot)
    );

    always_comb begin
        ownerOneHot = '0;
        grantVec    = '0;
        txData      = '0;
        txSOP       = 1'b0;
        txEOP       = 1'b0;
        txValid     = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            ownerOneHot[i] = (owner == ReqIdx'(i));
        end
        if (running) begin
            grantVec = locked ? ownerOneHot : pickOneHot;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grantVec[i]) begin
                txData  = bus.reqData_in[i];
                txSOP   = bus.reqSOP_in[i];
                txEOP   = bus.reqEOP_in[i];
                txValid = bus.reqValid_in[i];
            end
        end
        xfer   = txValid & bus.txReady_in;
        // owner restarting mid-packet, or an EOP beat nobody could be sending
        errNow = running & ((locked & |(ownerOneHot & bus.reqValid_in & bus.reqSOP_in)) |
                            (~locked & |(bus.reqEOP_in & bus.reqValid_in & ~bus.reqSOP_in & ~grantVec)));
    end

    always_ff @(posedge pcieClk_in or negedge pcieNRST_in) begin
        if (!pcieNRST_in) begin
            running   <= 1'b0;
            locked    <= 1'b0;
            owner     <= '0;
            lastGrant <= ReqIdx'(NUM_REQ - 1);
            protoErr  <= 1'b0;
        end else if (!running) begin
            running <= 1'b1;
        end else begin
            protoErr <= protoErr | errNow;
            if (xfer) begin
                if (!locked) begin
                    lastGrant <= pick;
                    if (!txEOP) begin
                        locked <= 1'b1;
                        owner  <= pick;
                    end
                end else if (txEOP) begin
                    locked <= 1'b0;
                end
            end
        end
    end

    assign bus.txData_out   = txData;
    assign bus.txSOP_out    = txSOP;
    assign bus.txEOP_out    = txEOP;
    assign bus.txValid_out  = txValid;
    assign bus.grant_out    = grantVec;
    assign bus.reqReady_out = grantVec & {NUM_REQ{bus.txReady_in}};
    assign bus.protoErr_out = protoErr;

`ifdef TLP_TX_ARB_STATS_EN
    PktCount [NUM_REQ-1:0] pktCount;

    always_ff @(posedge pcieClk_in or negedge pcieNRST_in) begin
        if (!pcieNRST_in) begin
            pktCount <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (xfer && txEOP && grantVec[i]) begin
                    pktCount[i] <= pktCount[i] + PktCount'(1);
                end
            end
        end
    end

    assign bus.pktCount_out = pktCount;
`endif

    // an unlocked grant is only ever given to a SOP beat
    assert property (@(posedge pcieClk_in) disable iff (!pcieNRST_in)
                     (running && !locked && txValid) |-> txSOP);

endmodule

// File: tb/tb_tlp_tx_arbiter.sv
// Directed bench for tlp_tx_arbiter: a NUM_REQ=2 instance for packet locking, backpressure, errors and reset,
// and a NUM_REQ=3 instance for rotation fairness and stray-EOP detection.
module tb_tlp_tx_arbiter;

    logic clk;
    logic rstN;
    int   total;
    int   bad;

    tlp_tx_arbiter_if #(.NUM_REQ(2)) a2 ();
    tlp_tx_arbiter_if #(.NUM_REQ(3)) a3 ();

    tlp_tx_arbiter #(.NUM_REQ(2)) dut2 (.pcieClk_in(clk), .pcieNRST_in(rstN), .bus(a2));
    tlp_tx_arbiter #(.NUM_REQ(3)) dut3 (.pcieClk_in(clk), .pcieNRST_in(rstN), .bus(a3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drv2(input int i, input logic v, input logic s, input logic e, input logic [63:0] d);
        a2.reqValid_in[i] = v;
        a2.reqSOP_in[i]   = s;
        a2.reqEOP_in[i]   = e;
        a2.reqData_in[i]  = d;
    endtask

    task automatic drv3(input int i, input logic v, input logic s, input logic e, input logic [63:0] d);
        a3.reqValid_in[i] = v;
        a3.reqSOP_in[i]   = s;
        a3.reqEOP_in[i]   = e;
        a3.reqData_in[i]  = d;
    endtask

    task automatic nextCyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rstN  = 1'b1;
        for (int i = 0; i < 2; i++) drv2(i, 1'b0, 1'b0, 1'b0, 64'h0);
        for (int i = 0; i < 3; i++) drv3(i, 1'b0, 1'b0, 1'b0, 64'h0);
        a2.txReady_in = 1'b1;
        a3.txReady_in = 1'b1;

        // reset state, with a request already pending
        #1 rstN = 1'b0;
        drv2(0, 1'b1, 1'b1, 1'b0, 64'hA1);
        #1;
        chk("rst_txValid", 64'(a2.txValid_out), 64'h0);
        chk("rst_grant", 64'(a2.grant_out), 64'h0);
        chk("rst_ready", 64'(a2.reqReady_out), 64'h0);
        chk("rst_data", a2.txData_out, 64'h0);
        chk("rst_protoErr", 64'(a2.protoErr_out), 64'h0);
        chk("rst3_grant", 64'(a3.grant_out), 64'h0);
        @(negedge clk) rstN = 1'b1;
        nextCyc();

        // both eligible, core stalled: first pick is req0, nothing accepted
        drv2(1, 1'b1, 1'b1, 1'b1, 64'hB1);
        a2.txReady_in = 1'b0;
        #1;
        chk("first_pick_grant", 64'(a2.grant_out), 64'h1);
        chk("first_pick_ready", 64'(a2.reqReady_out), 64'h0);
        chk("first_pick_valid", 64'(a2.txValid_out), 64'h1);
        nextCyc();

        // req0 3-beat TLP; req1 single-beat TLP raised at beat 2
        drv2(1, 1'b0, 1'b0, 1'b0, 64'h0);
        a2.txReady_in = 1'b1;
        #1;
        chk("A1_grant", 64'(a2.grant_out), 64'h1);
        chk("A1_data", a2.txData_out, 64'hA1);
        chk("A1_sop", 64'(a2.txSOP_out), 64'h1);
        chk("A1_ready", 64'(a2.reqReady_out), 64'h1);
        nextCyc();
        drv2(0, 1'b1, 1'b0, 1'b0, 64'hA2);
        drv2(1, 1'b1, 1'b1, 1'b1, 64'hB1);
        #1;
        chk("A2_grant", 64'(a2.grant_out), 64'h1);
        chk("A2_data", a2.txData_out, 64'hA2);
        chk("A2_ready", 64'(a2.reqReady_out), 64'h1);
        nextCyc();
        drv2(0, 1'b1, 1'b0, 1'b1, 64'hA3);
        #1;
        chk("A3_grant", 64'(a2.grant_out), 64'h1);
        chk("A3_data", a2.txData_out, 64'hA3);
        chk("A3_eop", 64'(a2.txEOP_out), 64'h1);
        nextCyc();
        drv2(0, 1'b0, 1'b0, 1'b0, 64'h0);
        #1;
        chk("B1_grant", 64'(a2.grant_out), 64'h2);
        chk("B1_data", a2.txData_out, 64'hB1);
        chk("B1_sopeop", 64'({a2.txSOP_out, a2.txEOP_out}), 64'h3);
        nextCyc();
        drv2(1, 1'b0, 1'b0, 1'b0, 64'h0);
        #1;
        chk("idle_grant", 64'(a2.grant_out), 64'h0);
        chk("idle_valid", 64'(a2.txValid_out), 64'h0);
        chk("idle_protoErr", 64'(a2.protoErr_out), 64'h0);

        // backpressure mid-packet while req1 waits
        drv2(0, 1'b1, 1'b1, 1'b0, 64'hC1);
        #1;
        chk("C1_grant", 64'(a2.grant_out), 64'h1);
        nextCyc();
        drv2(0, 1'b1, 1'b0, 1'b0, 64'hC2);
        drv2(1, 1'b1, 1'b1, 1'b1, 64'hB2);
        a2.txReady_in = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("stall%0d_grant", k), 64'(a2.grant_out), 64'h1);
            chk($sformatf("stall%0d_data", k), a2.txData_out, 64'hC2);
            chk($sformatf("stall%0d_ready", k), 64'(a2.reqReady_out), 64'h0);
            nextCyc();
        end
        a2.txReady_in = 1'b1;
        #1;
        chk("C2_resume_ready", 64'(a2.reqReady_out), 64'h1);
        chk("C2_resume_data", a2.txData_out, 64'hC2);
        nextCyc();
        drv2(0, 1'b1, 1'b0, 1'b1, 64'hC3);
        #1;
        chk("C3_grant", 64'(a2.grant_out), 64'h1);
        nextCyc();
        drv2(0, 1'b0, 1'b0, 1'b0, 64'h0);
        #1;
        chk("B2_grant", 64'(a2.grant_out), 64'h2);
        nextCyc();
        drv2(1, 1'b0, 1'b0, 1'b0, 64'h0);

        // owner re-asserts SOP mid-packet
        drv2(0, 1'b1, 1'b1, 1'b0, 64'hD1);
        #1;
        chk("D1_grant", 64'(a2.grant_out), 64'h1);
        nextCyc();
        drv2(0, 1'b1, 1'b1, 1'b0, 64'hD2);
        #1;
        chk("D2_protoErr_pre", 64'(a2.protoErr_out), 64'h0);
        chk("D2_grant", 64'(a2.grant_out), 64'h1);
        nextCyc();
        drv2(0, 1'b1, 1'b0, 1'b1, 64'hD3);
        #1;
        chk("D3_protoErr", 64'(a2.protoErr_out), 64'h1);
        chk("D3_data", a2.txData_out, 64'hD3);
        chk("D3_grant", 64'(a2.grant_out), 64'h1);
        nextCyc();
        drv2(0, 1'b0, 1'b0, 1'b0, 64'h0);
        #1;
        chk("D_sticky_protoErr", 64'(a2.protoErr_out), 64'h1);
        chk("D_idle_grant", 64'(a2.grant_out), 64'h0);
`ifdef TLP_TX_ARB_STATS_EN
        chk("cnt_req0", 64'(a2.pktCount_out[0]), 64'd3);
        chk("cnt_req1", 64'(a2.pktCount_out[1]), 64'd2);
`endif

        // reset in the middle of a locked packet
        drv2(0, 1'b1, 1'b1, 1'b0, 64'hE1);
        nextCyc();
        drv2(0, 1'b1, 1'b0, 1'b0, 64'hE2);
        #1;
        chk("E2_valid", 64'(a2.txValid_out), 64'h1);
        rstN = 1'b0;
        #1;
        chk("midrst_valid", 64'(a2.txValid_out), 64'h0);
        chk("midrst_grant", 64'(a2.grant_out), 64'h0);
        chk("midrst_protoErr", 64'(a2.protoErr_out), 64'h0);
`ifdef TLP_TX_ARB_STATS_EN
        chk("midrst_cnt0", 64'(a2.pktCount_out[0]), 64'd0);
`endif
        @(negedge clk) rstN = 1'b1;
        drv2(0, 1'b0, 1'b0, 1'b0, 64'h0);
        drv2(1, 1'b1, 1'b1, 1'b1, 64'hF1);
        nextCyc();
        #1;
        chk("F1_grant", 64'(a2.grant_out), 64'h2);
        chk("F1_data", a2.txData_out, 64'hF1);
        chk("F1_ready", 64'(a2.reqReady_out), 64'h2);
        nextCyc();
        drv2(1, 1'b0, 1'b0, 1'b0, 64'h0);

        // NUM_REQ=3 rotation with everyone continuously eligible
        for (int i = 0; i < 3; i++) drv3(i, 1'b1, 1'b1, 1'b1, 64'h30 + 64'(i));
        for (int k = 0; k < 6; k++) begin
            #1;
            chk($sformatf("rr%0d_grant", k), 64'(a3.grant_out), 64'(1 << (k % 3)));
            chk($sformatf("rr%0d_data", k), a3.txData_out, 64'h30 + 64'(k % 3));
            nextCyc();
        end
        for (int i = 0; i < 3; i++) drv3(i, 1'b0, 1'b0, 1'b0, 64'h0);
        #1;
        chk("rr_protoErr", 64'(a3.protoErr_out), 64'h0);

        // EOP without SOP from a requester that was never granted
        drv3(0, 1'b1, 1'b0, 1'b1, 64'h77);
        #1;
        chk("stray_grant", 64'(a3.grant_out), 64'h0);
        chk("stray_valid", 64'(a3.txValid_out), 64'h0);
        nextCyc();
        drv3(0, 1'b0, 1'b0, 1'b0, 64'h0);
        #1;
        chk("stray_protoErr", 64'(a3.protoErr_out), 64'h1);
        chk("stray_other_dut", 64'(a2.protoErr_out), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
